aes_egress_buffer: RTL and testbench

- Egress stage directly downstream of the AES-GCM API block.
- Captures each ciphered word ({cipher 128b, bypass 289b, last}) on the upstream ready strobe and holds it in a FIFO. Drains it to the next stage over a valid/ready stream.
- Upstream cannot be stalled, so the block has packet-granular overflow handling: truncated packets are closed with an error-flagged terminator, and packets that find the buffer full at their start are dropped whole.

---
 rtl/aes_egress_buffer.sv | 141 ++++++++++++++
 tb/tb_aes_egress_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_egress_buffer.sv
// Egress FIFO behind the AES-GCM block with packet-granular overflow handling.
// Optional statistics counters are enabled with `define AES_EGRESS_STATS_EN.
module aes_egress_buffer #(
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4,
  parameter int BYPASS_W  = 289
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_cp_ready,
  input  logic [0:127]             i_cipher_text,
  input  logic [BYPASS_W-1:0]      i_bypass_text,
  input  logic                     i_last,
  output logic                     o_m_valid,
  input  logic                     i_m_ready,
  output logic [0:127]             o_m_cipher,
  output logic [BYPASS_W-1:0]      o_m_bypass,
  output logic                     o_m_last,
  output logic                     o_m_err,
  output logic                     o_almost_full,
  output logic                     o_overflow,
`ifdef AES_EGRESS_STATS_EN
  output logic [31:0]              o_pkt_cnt,
  output logic [31:0]              o_drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 128 + BYPASS_W + 2;

  typedef enum logic {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} state_t;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_inPkt;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_pushEntry;
  logic [EW-1:0] w_head;

  // The last slot is held back so a truncated packet can always be closed.
  assign w_full = r_count >= CW'(DEPTH - 1);
  assign w_pop  = (r_count != '0) && i_m_ready;

  always_comb begin
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_pushEntry = '0;
    if (i_cp_ready) begin
      if (r_state == ST_DROP) begin
        w_drop = 1'b1;
      end else if (!w_full) begin
        w_push      = 1'b1;
        w_pushEntry = {i_cipher_text, i_bypass_text, i_last, 1'b0};
      end else if (r_inPkt) begin
        w_push      = 1'b1;
        w_drop      = 1'b1;
        w_pushEntry = {128'b0, {BYPASS_W{1'b0}}, 1'b1, 1'b1};
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_pushEntry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_state    <= ST_ACCEPT;
      r_inPkt    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      if (i_cp_ready) begin
        case (r_state)
          ST_ACCEPT: begin
            if (!w_full) begin
              r_inPkt <= !i_last;
            end else begin
              r_inPkt <= 1'b0;
              if (!i_last) r_state <= ST_DROP;
            end
          end
          ST_DROP: begin
            if (i_last) r_state <= ST_ACCEPT;
          end
          default: r_state <= ST_ACCEPT;
        endcase
      end
    end
  end

  assign w_head = r_mem[r_rdPtr];

  assign o_m_valid = r_count != '0;
  assign {o_m_cipher, o_m_bypass, o_m_last, o_m_err} = o_m_valid ? w_head : '0;
  assign o_almost_full = r_count >= CW'(DEPTH - AF_MARGIN);
  assign o_overflow    = r_overflow;
  assign o_count       = r_count;

`ifdef AES_EGRESS_STATS_EN
  logic [31:0] r_pktCnt;
  logic [31:0] r_dropCnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pktCnt  <= '0;
      r_dropCnt <= '0;
    end else begin
      if (w_pop && o_m_last && !o_m_err && (r_pktCnt != '1)) r_pktCnt <= r_pktCnt + 1'b1;
      if (w_drop && (r_dropCnt != '1)) r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

  assign o_pkt_cnt  = r_pktCnt;
  assign o_drop_cnt = r_dropCnt;
`endif

endmodule

// File: tb/tb_aes_egress_buffer.sv
// Randomized self-checking bench for aes_egress_buffer against a queue-based packet model.
// Works with and without AES_EGRESS_STATS_EN defined.
module tb_aes_egress_buffer;

  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 4;
  localparam int BW        = 289;

  logic              clk;
  logic              reset;
  logic              i_cp_ready;
  logic [0:127]      i_cipher_text;
  logic [BW-1:0]     i_bypass_text;
  logic              i_last;
  logic              o_m_valid;
  logic              i_m_ready;
  logic [0:127]      o_m_cipher;
  logic [BW-1:0]     o_m_bypass;
  logic              o_m_last;
  logic              o_m_err;
  logic              o_almost_full;
  logic              o_overflow;
  logic [4:0]        o_count;
`ifdef AES_EGRESS_STATS_EN
  logic [31:0]       o_pkt_cnt;
  logic [31:0]       o_drop_cnt;
`endif

  aes_egress_buffer #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .BYPASS_W(BW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cp_ready    (i_cp_ready),
    .i_cipher_text (i_cipher_text),
    .i_bypass_text (i_bypass_text),
    .i_last        (i_last),
    .o_m_valid     (o_m_valid),
    .i_m_ready     (i_m_ready),
    .o_m_cipher    (o_m_cipher),
    .o_m_bypass    (o_m_bypass),
    .o_m_last      (o_m_last),
    .o_m_err       (o_m_err),
    .o_almost_full (o_almost_full),
    .o_overflow    (o_overflow),
`ifdef AES_EGRESS_STATS_EN
    .o_pkt_cnt     (o_pkt_cnt),
    .o_drop_cnt    (o_drop_cnt),
`endif
    .o_count       (o_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [0:127]  c;
    logic [BW-1:0] b;
    logic          l;
    logic          e;
  } entry_t;

  entry_t      modelQ[$];
  logic        modelDrop;
  logic        modelInPkt;
  logic        modelOvf;
  int unsigned modelPktCnt;
  int unsigned modelDropCnt;

  int checkCount;
  int errCount;

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [BW-1:0] randBypass();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[BW-1:0];
  endfunction

  function automatic logic [0:127] randCipher();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic modelClear();
    modelQ.delete();
    modelDrop    = 1'b0;
    modelInPkt   = 1'b0;
    modelOvf     = 1'b0;
    modelPktCnt  = 0;
    modelDropCnt = 0;
  endtask

  task automatic compareAll();
    entry_t head;
    int     n;
    n    = modelQ.size();
    head = (n > 0) ? modelQ[0] : '0;
    checkOutput("valid",  512'(o_m_valid),     512'(n > 0));
    checkOutput("count",  512'(o_count),       512'(n));
    checkOutput("afull",  512'(o_almost_full), 512'(n >= DEPTH - AF_MARGIN));
    checkOutput("ovf",    512'(o_overflow),    512'(modelOvf));
    checkOutput("cipher", 512'(o_m_cipher),    512'(head.c));
    checkOutput("bypass", 512'(o_m_bypass),    512'(head.b));
    checkOutput("last",   512'(o_m_last),      512'(head.l));
    checkOutput("err",    512'(o_m_err),       512'(head.e));
`ifdef AES_EGRESS_STATS_EN
    checkOutput("pktcnt",  512'(o_pkt_cnt),  512'(modelPktCnt));
    checkOutput("dropcnt", 512'(o_drop_cnt), 512'(modelDropCnt));
`endif
  endtask

  // Packet-level reference: space is judged on the occupancy before this cycle's pop.
  task automatic modelStep();
    int     n;
    logic   doPop;
    entry_t e;
    n     = modelQ.size();
    doPop = (n > 0) && i_m_ready;
    if (doPop && modelQ[0].l && !modelQ[0].e) modelPktCnt++;
    if (doPop) void'(modelQ.pop_front());
    if (i_cp_ready) begin
      if (modelDrop) begin
        modelOvf = 1'b1;
        modelDropCnt++;
        if (i_last) modelDrop = 1'b0;
      end else if (n < DEPTH - 1) begin
        e.c = i_cipher_text; e.b = i_bypass_text; e.l = i_last; e.e = 1'b0;
        modelQ.push_back(e);
        modelInPkt = !i_last;
      end else begin
        if (modelInPkt) begin
          e = '0; e.l = 1'b1; e.e = 1'b1;
          modelQ.push_back(e);
          modelInPkt = 1'b0;
        end
        modelOvf = 1'b1;
        modelDropCnt++;
        modelDrop = !i_last;
      end
    end
  endtask

  task automatic applyStimulus(input logic cp, input logic last, input logic rdy);
    i_cp_ready    = cp;
    i_last        = last;
    i_m_ready     = rdy;
    i_cipher_text = randCipher();
    i_bypass_text = randBypass();
    @(negedge clk);
    compareAll();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset      = 1'b1;
    i_cp_ready = 1'b0;
    i_m_ready  = 1'b0;
    i_last     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelClear();
  endtask

  initial begin
    checkCount = 0;
    errCount   = 0;
    reset         = 1'b0;
    i_cp_ready    = 1'b0;
    i_last        = 1'b0;
    i_m_ready     = 1'b0;
    i_cipher_text = '0;
    i_bypass_text = '0;
    modelClear();
    @(posedge clk);
    #1;

    applyReset();
    checkOutput("rst_valid", 512'(o_m_valid),  512'(0));
    checkOutput("rst_count", 512'(o_count),    512'(0));
    checkOutput("rst_ovf",   512'(o_overflow), 512'(0));

    // Three-word packet streamed straight through.
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

    // Fill while stalled, truncate, drop the tail, then drain.
    applyReset();
    repeat (16) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("fill_count", 512'(o_count),    512'(16));
    checkOutput("fill_ovf",   512'(o_overflow), 512'(1));
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (18) applyStimulus(1'b0, 1'b0, 1'b1);

    // Buffer at 15 between packets: new packet is dropped without a terminator.
    applyReset();
    repeat (14) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("gap_count", 512'(o_count), 512'(15));
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (17) applyStimulus(1'b0, 1'b0, 1'b1);

    // Push with a simultaneous pop at 15 mid-packet still counts as full.
    applyReset();
    repeat (15) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("pp_count", 512'(o_count), 512'(15));
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (17) applyStimulus(1'b0, 1'b0, 1'b1);

    // Random traffic with varying downstream pressure.
    applyReset();
    for (int blk = 0; blk < 8; blk++) begin
      int rdyPct;
      rdyPct = (blk % 4) * 30 + 5;
      for (int i = 0; i < 250; i++) begin
        applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 99) < rdyPct);
      end
    end

    // Reset with eight entries queued and overflow already set.
    applyReset();
    repeat (17) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pre_count", 512'(o_count),    512'(8));
    checkOutput("pre_ovf",   512'(o_overflow), 512'(1));
    applyReset();
    checkOutput("r8_count", 512'(o_count),    512'(0));
    checkOutput("r8_valid", 512'(o_m_valid),  512'(0));
    checkOutput("r8_ovf",   512'(o_overflow), 512'(0));
`ifdef AES_EGRESS_STATS_EN
    checkOutput("r8_pkt",  512'(o_pkt_cnt),  512'(0));
    checkOutput("r8_drop", 512'(o_drop_cnt), 512'(0));
`endif
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
